// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle RV32I-subset controller.
// TRAP state exists only when ILLEGAL_OP_TRAP_EN is defined.
package riscv_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECUTER, EXECUTEI, ALUWB, BEQ, JAL
`ifdef ILLEGAL_OP_TRAP_EN
    , TRAP
`endif
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  function automatic logic [1:0] imm_sel(input logic [6:0] op);
    case (op)
      OP_SW:   return IMM_S;
      OP_BEQ:  return IMM_B;
      OP_JAL:  return IMM_J;
      default: return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle: instruction fields and flags in, selects and strobes out.
// The illegal flag is present only when ILLEGAL_OP_TRAP_EN is defined.
interface multicycle_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;
  logic [1:0] immsrc;
  logic [1:0] alusrca;
  logic [1:0] alusrcb;
  logic [1:0] resultsrc;
  logic       adrsrc;
  logic [2:0] alucontrol;
  logic       irwrite;
  logic       pcwrite;
  logic       regwrite;
  logic       memwrite;
`ifdef ILLEGAL_OP_TRAP_EN
  logic       illegal;
`endif

  modport master (
`ifdef ILLEGAL_OP_TRAP_EN
    output illegal,
`endif
    input  op, funct3, funct7b5, zero, mem_ready,
    output immsrc, alusrca, alusrcb, resultsrc, adrsrc, alucontrol,
    output irwrite, pcwrite, regwrite, memwrite
  );

  modport slave (
`ifdef ILLEGAL_OP_TRAP_EN
    input  illegal,
`endif
    output op, funct3, funct7b5, zero, mem_ready,
    input  immsrc, alusrca, alusrcb, resultsrc, adrsrc, alucontrol,
    input  irwrite, pcwrite, regwrite, memwrite
  );
endinterface

// File: rtl/alu_decoder.sv
// Maps aluop plus instruction fields to the 3-bit ALU operation.
module alu_decoder
  import riscv_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // funct7b5 selects sub only for R-type; addi ignores it
          3'b000:  alucontrol = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alucontrol = ALU_SLT;
          3'b110:  alucontrol = ALU_OR;
          3'b111:  alucontrol = ALU_AND;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle core; Moore outputs with mem_ready/zero-gated strobes.
// Define ILLEGAL_OP_TRAP_EN to trap unsupported opcodes instead of skipping them.
module multicycle_controller
  import riscv_pkg::*;
#(
  parameter state_t RESET_STATE = FETCH
) (
  input logic                     clk,
  input logic                     reset_n,
  multicycle_controller_if.master ctrl
);

  state_t     state, next_state, view;
  logic [1:0] aluop;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= RESET_STATE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      FETCH:    if (ctrl.mem_ready) next_state = DECODE;
      DECODE: begin
        case (ctrl.op)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_R:         next_state = EXECUTER;
          OP_I:         next_state = EXECUTEI;
          OP_BEQ:       next_state = BEQ;
          OP_JAL:       next_state = JAL;
`ifdef ILLEGAL_OP_TRAP_EN
          default:      next_state = TRAP;
`else
          default:      next_state = FETCH;
`endif
        endcase
      end
      MEMADR:   next_state = (ctrl.op == OP_LW) ? MEMREAD : MEMWRITE;
      MEMREAD:  if (ctrl.mem_ready) next_state = MEMWB;
      MEMWRITE: if (ctrl.mem_ready) next_state = FETCH;
      MEMWB, ALUWB, BEQ:   next_state = FETCH;
      EXECUTER, EXECUTEI, JAL: next_state = ALUWB;
      default:  next_state = state;
    endcase
  end

  // During reset the muxes show FETCH decode and every strobe is held low
  always_comb begin
    view           = reset_n ? state : FETCH;
    ctrl.alusrca   = SRCA_PC;
    ctrl.alusrcb   = SRCB_RS2;
    ctrl.resultsrc = RES_ALUOUT;
    ctrl.adrsrc    = 1'b0;
    aluop          = ALUOP_ADD;
    ctrl.irwrite   = 1'b0;
    ctrl.pcwrite   = 1'b0;
    ctrl.regwrite  = 1'b0;
    ctrl.memwrite  = 1'b0;
`ifdef ILLEGAL_OP_TRAP_EN
    ctrl.illegal   = 1'b0;
`endif
    case (view)
      FETCH: begin
        ctrl.alusrcb   = SRCB_FOUR;
        ctrl.resultsrc = RES_ALURESULT;
        ctrl.irwrite   = ctrl.mem_ready;
        ctrl.pcwrite   = ctrl.mem_ready;
      end
      DECODE: begin
        ctrl.alusrca = SRCA_OLDPC;
        ctrl.alusrcb = SRCB_IMM;
      end
      MEMADR: begin
        ctrl.alusrca = SRCA_RS1;
        ctrl.alusrcb = SRCB_IMM;
      end
      MEMREAD:  ctrl.adrsrc = 1'b1;
      MEMWB: begin
        ctrl.resultsrc = RES_DATA;
        ctrl.regwrite  = 1'b1;
      end
      MEMWRITE: begin
        ctrl.adrsrc   = 1'b1;
        ctrl.memwrite = 1'b1;
      end
      EXECUTER: begin
        ctrl.alusrca = SRCA_RS1;
        aluop        = ALUOP_FUNCT;
      end
      EXECUTEI: begin
        ctrl.alusrca = SRCA_RS1;
        ctrl.alusrcb = SRCB_IMM;
        aluop        = ALUOP_FUNCT;
      end
      ALUWB:    ctrl.regwrite = 1'b1;
      BEQ: begin
        ctrl.alusrca = SRCA_RS1;
        aluop        = ALUOP_SUB;
        ctrl.pcwrite = ctrl.zero;
      end
      JAL: begin
        ctrl.alusrca = SRCA_OLDPC;
        ctrl.alusrcb = SRCB_FOUR;
        ctrl.pcwrite = 1'b1;
      end
`ifdef ILLEGAL_OP_TRAP_EN
      TRAP:     ctrl.illegal = 1'b1;
`endif
      default: ;
    endcase
    if (!reset_n) begin
      ctrl.irwrite  = 1'b0;
      ctrl.pcwrite  = 1'b0;
      ctrl.regwrite = 1'b0;
      ctrl.memwrite = 1'b0;
    end
  end

  assign ctrl.immsrc = imm_sel(ctrl.op);

  alu_decoder u_alu_decoder (
    .aluop      (aluop),
    .funct3     (ctrl.funct3),
    .op5        (ctrl.op[5]),
    .funct7b5   (ctrl.funct7b5),
    .alucontrol (ctrl.alucontrol)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed self-checking bench for multicycle_controller; expected outputs are hand-coded per state.
module tb_multicycle_controller;

  logic clk = 1'b0;
  logic reset_n;
  int   errors = 0;
  int   checks = 0;

  multicycle_controller_if bus ();

  multicycle_controller #(.RESET_STATE(riscv_pkg::FETCH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .ctrl    (bus.master)
  );

  always #5 clk = ~clk;

  // {immsrc, alusrca, alusrcb, resultsrc, adrsrc, alucontrol, irwrite, pcwrite, regwrite, memwrite}
  function automatic logic [15:0] outs();
    return {bus.immsrc, bus.alusrca, bus.alusrcb, bus.resultsrc, bus.adrsrc,
            bus.alucontrol, bus.irwrite, bus.pcwrite, bus.regwrite, bus.memwrite};
  endfunction

  function automatic logic [15:0] e_fetch(input logic [1:0] im, input logic mr);
    return {im, 2'b00, 2'b10, 2'b10, 1'b0, 3'b000, mr, mr, 1'b0, 1'b0};
  endfunction
  function automatic logic [15:0] e_rst(input logic [1:0] im);
    return {im, 2'b00, 2'b10, 2'b10, 1'b0, 3'b000, 4'b0000};
  endfunction
  function automatic logic [15:0] e_decode(input logic [1:0] im);
    return {im, 2'b01, 2'b01, 2'b00, 1'b0, 3'b000, 4'b0000};
  endfunction
  function automatic logic [15:0] e_memadr(input logic [1:0] im);
    return {im, 2'b10, 2'b01, 2'b00, 1'b0, 3'b000, 4'b0000};
  endfunction
  function automatic logic [15:0] e_memread();
    return {2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 3'b000, 4'b0000};
  endfunction
  function automatic logic [15:0] e_memwb();
    return {2'b00, 2'b00, 2'b00, 2'b01, 1'b0, 3'b000, 4'b0010};
  endfunction
  function automatic logic [15:0] e_memwrite();
    return {2'b01, 2'b00, 2'b00, 2'b00, 1'b1, 3'b000, 4'b0001};
  endfunction
  function automatic logic [15:0] e_exec(input logic [1:0] srcb, input logic [2:0] alu);
    return {2'b00, 2'b10, srcb, 2'b00, 1'b0, alu, 4'b0000};
  endfunction
  function automatic logic [15:0] e_aluwb(input logic [1:0] im);
    return {im, 2'b00, 2'b00, 2'b00, 1'b0, 3'b000, 4'b0010};
  endfunction
  function automatic logic [15:0] e_beq(input logic z);
    return {2'b10, 2'b10, 2'b00, 2'b00, 1'b0, 3'b001, 1'b0, z, 1'b0, 1'b0};
  endfunction
  function automatic logic [15:0] e_jal();
    return {2'b11, 2'b01, 2'b10, 2'b00, 1'b0, 3'b000, 4'b0100};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    bus.op = op;
    bus.funct3 = f3;
    bus.funct7b5 = f7;
  endtask

  task automatic test_reset();
    logic [15:0] got;
    reset_n = 1'b0;
    bus.mem_ready = 1'b1;
    bus.zero = 1'b0;
    set_instr(7'b0000011, 3'b010, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step();
      got = outs();
      if (got !== e_rst(2'b00)) begin
        $display("FAIL reset[%0d] got=%h exp=%h", i, got, e_rst(2'b00));
        errors++;
      end
      checks++;
    end
    reset_n = 1'b1;
    #1;
    got = outs();
    if (got !== e_fetch(2'b00, 1'b1)) begin
      $display("FAIL reset_release got=%h exp=%h", got, e_fetch(2'b00, 1'b1));
      errors++;
    end
    checks++;
  endtask

  // lw with a wait in FETCH and one in MEMREAD
  task automatic test_lw();
    logic [15:0] exp [7];
    logic        mr  [7];
    logic [15:0] got;
    set_instr(7'b0000011, 3'b010, 1'b0);
    exp = '{e_fetch(2'b00, 1'b0), e_fetch(2'b00, 1'b1), e_decode(2'b00), e_memadr(2'b00),
            e_memread(), e_memread(), e_memwb()};
    mr  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 7; i++) begin
      bus.mem_ready = mr[i];
      #1;
      got = outs();
      if (got !== exp[i]) begin
        $display("FAIL lw[%0d] got=%h exp=%h", i, got, exp[i]);
        errors++;
      end
      checks++;
      step();
    end
  endtask

  task automatic test_sw_wait();
    logic [15:0] exp [7];
    logic        mr  [7];
    logic [15:0] got;
    set_instr(7'b0100011, 3'b010, 1'b0);
    exp = '{e_fetch(2'b01, 1'b1), e_decode(2'b01), e_memadr(2'b01),
            e_memwrite(), e_memwrite(), e_memwrite(), e_fetch(2'b01, 1'b1)};
    mr  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 7; i++) begin
      bus.mem_ready = mr[i];
      #1;
      got = outs();
      if (got !== exp[i]) begin
        $display("FAIL sw[%0d] got=%h exp=%h", i, got, exp[i]);
        errors++;
      end
      checks++;
      if (i < 6) step();
    end
  endtask

  task automatic test_beq(input logic z);
    logic [15:0] exp [3];
    logic [15:0] got;
    set_instr(7'b1100011, 3'b000, 1'b0);
    bus.mem_ready = 1'b1;
    bus.zero = z;
    exp = '{e_fetch(2'b10, 1'b1), e_decode(2'b10), e_beq(z)};
    for (int i = 0; i < 3; i++) begin
      #1;
      got = outs();
      if (got !== exp[i]) begin
        $display("FAIL beq_z%0b[%0d] got=%h exp=%h", z, i, got, exp[i]);
        errors++;
      end
      checks++;
      step();
    end
    bus.zero = 1'b0;
  endtask

  task automatic test_alu_op(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                             input logic [2:0] alu);
    logic [15:0] exp [4];
    logic [15:0] got;
    logic [1:0]  srcb;
    srcb = op[5] ? 2'b00 : 2'b01;
    set_instr(op, f3, f7);
    bus.mem_ready = 1'b1;
    exp = '{e_fetch(2'b00, 1'b1), e_decode(2'b00), e_exec(srcb, alu), e_aluwb(2'b00)};
    for (int i = 0; i < 4; i++) begin
      #1;
      got = outs();
      if (got !== exp[i]) begin
        $display("FAIL alu_op%h_f3%0d_f7%0b[%0d] got=%h exp=%h", op, f3, f7, i, got, exp[i]);
        errors++;
      end
      checks++;
      step();
    end
  endtask

  task automatic test_jal();
    logic [15:0] exp [4];
    logic [15:0] got;
    set_instr(7'b1101111, 3'b000, 1'b0);
    bus.mem_ready = 1'b1;
    exp = '{e_fetch(2'b11, 1'b1), e_decode(2'b11), e_jal(), e_aluwb(2'b11)};
    for (int i = 0; i < 4; i++) begin
      #1;
      got = outs();
      if (got !== exp[i]) begin
        $display("FAIL jal[%0d] got=%h exp=%h", i, got, exp[i]);
        errors++;
      end
      checks++;
      step();
    end
  endtask

  task automatic test_reset_in_jal();
    logic [15:0] exp [6];
    logic        rn  [6];
    logic [15:0] got;
    set_instr(7'b1101111, 3'b000, 1'b0);
    bus.mem_ready = 1'b1;
    exp = '{e_fetch(2'b11, 1'b1), e_decode(2'b11), e_jal(), e_rst(2'b11), e_rst(2'b11),
            e_fetch(2'b11, 1'b1)};
    rn  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      reset_n = rn[i];
      #1;
      got = outs();
      if (got !== exp[i]) begin
        $display("FAIL jal_reset[%0d] got=%h exp=%h", i, got, exp[i]);
        errors++;
      end
      checks++;
      if (i != 3 && i != 5) step();
    end
  endtask

  task automatic test_unknown_op();
    logic [15:0] got;
    set_instr(7'b0000000, 3'b000, 1'b0);
    bus.mem_ready = 1'b1;
    #1;
    step();
    got = outs();
    if (got !== e_decode(2'b00)) begin
      $display("FAIL unk_decode got=%h exp=%h", got, e_decode(2'b00));
      errors++;
    end
    checks++;
    step();
    got = outs();
`ifdef ILLEGAL_OP_TRAP_EN
    if ({bus.illegal, got} !== {1'b1, 16'h0000}) begin
      $display("FAIL unk_trap got=%b_%h exp=1_0000", bus.illegal, got);
      errors++;
    end
    checks++;
    step();
    if (bus.illegal !== 1'b1) begin
      $display("FAIL unk_trap_hold got=%b exp=1", bus.illegal);
      errors++;
    end
    checks++;
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    #1;
    got = outs();
`endif
    if (got !== e_fetch(2'b00, 1'b1)) begin
      $display("FAIL unk_refetch got=%h exp=%h", got, e_fetch(2'b00, 1'b1));
      errors++;
    end
    checks++;
  endtask

  initial begin
    reset_n = 1'b0;
    bus.mem_ready = 1'b1;
    bus.zero = 1'b0;
    set_instr(7'b0000000, 3'b000, 1'b0);
    test_reset();
    test_lw();
    test_sw_wait();
    test_beq(1'b1);
    test_beq(1'b0);
    test_alu_op(7'b0110011, 3'b000, 1'b1, 3'b001);
    test_alu_op(7'b0110011, 3'b000, 1'b0, 3'b000);
    test_alu_op(7'b0110011, 3'b010, 1'b0, 3'b101);
    test_alu_op(7'b0110011, 3'b110, 1'b0, 3'b011);
    test_alu_op(7'b0110011, 3'b111, 1'b0, 3'b010);
    test_alu_op(7'b0110011, 3'b001, 1'b0, 3'b000);
    test_alu_op(7'b0010011, 3'b000, 1'b1, 3'b000);
    test_alu_op(7'b0010011, 3'b110, 1'b0, 3'b011);
    test_jal();
    test_reset_in_jal();
    test_unknown_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
